f11_vic: RTL and testbench

//  Vectored interrupt controller directly downstream of the F-11 core's interrupt bus
//  (wbi_stb/wbi_una/wbi_ack/wbi_dat). Collects level requests from N peripherals and folds

---
 rtl/f11_vic_pkg.sv | 18 +
 rtl/f11_vic_penc.sv | 33 +++
 rtl/f11_vic.sv | 126 ++++++++++++
 tb/tb_f11_vic.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/f11_vic_pkg.sv
// Shared definitions for the F-11 vectored interrupt controller.
package f11_vic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACK    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_NORESP = 2'd3
    } state_t;

    localparam logic [1:0] BR4 = 2'd0;
    localparam logic [1:0] BR5 = 2'd1;
    localparam logic [1:0] BR6 = 2'd2;
    localparam logic [1:0] BR7 = 2'd3;

    localparam int VEC_W = 9;

endpackage

// File: rtl/f11_vic_penc.sv
// Two-key priority encoder: highest level wins, ties resolved to the lowest index.
module f11_vic_penc
    import f11_vic_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]   req_i,
    input  logic [2*N-1:0] lvl_i,
    output logic           any_o,
    output logic [3:0]     idx_o
);

    logic       found;
    logic [1:0] best_lvl;
    logic [3:0] best_idx;

    always_comb begin
        found    = 1'b0;
        best_lvl = BR4;
        best_idx = 4'd0;
        // Strictly-greater compare keeps the earlier (lower) index on a tie.
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && (!found || (lvl_i[2*i +: 2] > best_lvl))) begin
                found    = 1'b1;
                best_lvl = lvl_i[2*i +: 2];
                best_idx = 4'(i);
            end
        end
        any_o = found;
        idx_o = best_idx;
    end

endmodule

// File: rtl/f11_vic.sv
// Vectored interrupt controller on the F-11 interrupt bus: level folding,
// vector-read arbitration with a single acknowledge pulse, and fast-input reads.
module f11_vic
    import f11_vic_pkg::*;
#(
    parameter int N = 8
) (
    input  logic               vm_clk_p,
    input  logic               vm_init,
    input  logic [N-1:0]       ireq_i,
    input  logic [2*N-1:0]     ilvl_i,
    input  logic [VEC_W*N-1:0] ivec_i,
    output logic [N-1:0]       iack_o,
    input  logic [15:0]        una_dat_i,
    output logic [3:0]         vm_virq,
    input  logic               wbi_stb_i,
    input  logic               wbi_una_i,
    output logic               wbi_ack_o,
    output logic [15:0]        wbi_dat_o
);

    state_t             state_q, state_d;
    logic [3:0]         virq_q, virq_d;
    logic [3:0]         win_q, win_d;
    logic               iack_en_q, iack_en_d;
    logic               ack_q, ack_d;
    logic [15:0]        dat_q, dat_d;

    logic               any;
    logic [3:0]         idx;
    logic [VEC_W-1:0]   vec_sel;

    f11_vic_penc #(.N(N)) u_penc (
        .req_i (ireq_i),
        .lvl_i (ilvl_i),
        .any_o (any),
        .idx_o (idx)
    );

    always_comb begin
        virq_d = '0;
        for (int i = 0; i < N; i++) begin
            virq_d[ilvl_i[2*i +: 2]] = virq_d[ilvl_i[2*i +: 2]] | ireq_i[i];
        end
    end

    always_comb begin
        vec_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == 4'(i)) begin
                vec_sel = ivec_i[VEC_W*i +: VEC_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        dat_d     = dat_q;
        ack_d     = 1'b0;
        iack_en_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wbi_stb_i) begin
                    if (wbi_una_i) begin
                        state_d = ST_ACK;
                        dat_d   = una_dat_i;
                        ack_d   = 1'b1;
                    end else if (any) begin
                        state_d   = ST_ACK;
                        win_d     = idx;
                        dat_d     = {7'b0, vec_sel & 9'h1FC};
                        ack_d     = 1'b1;
                        iack_en_d = 1'b1;
                    end else begin
                        state_d = ST_NORESP;
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_WAIT;
            end
            ST_WAIT, ST_NORESP: begin
                // Stay parked until the core releases the strobe: one ack per strobe.
                if (!wbi_stb_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge vm_clk_p or posedge vm_init) begin
        if (vm_init) begin
            state_q   <= ST_IDLE;
            virq_q    <= '0;
            win_q     <= '0;
            iack_en_q <= 1'b0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
        end else begin
            state_q   <= state_d;
            virq_q    <= virq_d;
            win_q     <= win_d;
            iack_en_q <= iack_en_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
        end
    end

    always_comb begin
        iack_o = '0;
        for (int i = 0; i < N; i++) begin
            if (iack_en_q && (win_q == 4'(i))) begin
                iack_o[i] = 1'b1;
            end
        end
    end

    assign vm_virq   = virq_q;
    assign wbi_ack_o = ack_q;
    assign wbi_dat_o = dat_q;

endmodule

// File: tb/tb_f11_vic.sv
// Bench for f11_vic: behavioural bus model compared every cycle, plus directed literal checks.
module tb_f11_vic;

    localparam int N = 8;

    logic            clk = 1'b0;
    logic            vm_init = 1'b1;
    logic [N-1:0]    ireq = '0;
    logic [2*N-1:0]  lvl = '0;
    logic [9*N-1:0]  vec = '0;
    logic [N-1:0]    iack_o;
    logic [15:0]     una_dat = '0;
    logic [3:0]      vm_virq;
    logic            stb = 1'b0;
    logic            una = 1'b0;
    logic            wbi_ack_o;
    logic [15:0]     wbi_dat_o;

    int n_chk = 0;
    int n_err = 0;

    f11_vic #(.N(N)) dut (
        .vm_clk_p  (clk),
        .vm_init   (vm_init),
        .ireq_i    (ireq),
        .ilvl_i    (lvl),
        .ivec_i    (vec),
        .iack_o    (iack_o),
        .una_dat_i (una_dat),
        .vm_virq   (vm_virq),
        .wbi_stb_i (stb),
        .wbi_una_i (una),
        .wbi_ack_o (wbi_ack_o),
        .wbi_dat_o (wbi_dat_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one served transfer per strobe; after an ack the release
    // of the strobe is only noticed from the second edge on.
    logic [3:0]   m_virq = '0;
    logic         m_ack = 1'b0;
    logic [N-1:0] m_iack = '0;
    logic [15:0]  m_dat = '0;
    bit           m_engaged = 1'b0;
    bit           m_grace = 1'b0;

    function automatic int winner(input logic [N-1:0] r, input logic [2*N-1:0] l);
        for (int lv = 3; lv >= 0; lv--)
            for (int i = 0; i < N; i++)
                if (r[i] && (int'(l[2*i +: 2]) == lv)) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge vm_init) begin
        if (vm_init) begin
            m_virq = '0; m_ack = 1'b0; m_iack = '0; m_dat = '0;
            m_engaged = 1'b0; m_grace = 1'b0;
        end else begin
            int w;
            logic [8:0] v;
            m_virq = '0;
            for (int i = 0; i < N; i++)
                if (ireq[i]) m_virq[lvl[2*i +: 2]] = 1'b1;
            m_ack = 1'b0;
            m_iack = '0;
            if (!m_engaged) begin
                if (stb) begin
                    m_engaged = 1'b1;
                    if (una) begin
                        m_ack = 1'b1; m_dat = una_dat; m_grace = 1'b1;
                    end else begin
                        w = winner(ireq, lvl);
                        if (w >= 0) begin
                            v = vec[9*w +: 9];
                            m_ack = 1'b1;
                            m_iack = N'(1) << w;
                            m_dat = {7'd0, v[8:2], 2'b00};
                            m_grace = 1'b1;
                        end else begin
                            m_grace = 1'b0;
                        end
                    end
                end
            end else if (m_grace) begin
                m_grace = 1'b0;
            end else if (!stb) begin
                m_engaged = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        check("virq", 32'(vm_virq), 32'(m_virq));
        check("ack", 32'(wbi_ack_o), 32'(m_ack));
        check("iack", 32'(iack_o), 32'(m_iack));
        check("dat", 32'(wbi_dat_o), 32'(m_dat));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_src(input int i, input logic [1:0] l, input logic [8:0] v, input logic r);
        lvl[2*i +: 2] = l;
        vec[9*i +: 9] = v;
        ireq[i] = r;
    endtask

    initial begin
        int acks;
        cyc(3);
        check("rst_ack", 32'(wbi_ack_o), 32'd0);
        check("rst_dat", 32'(wbi_dat_o), 32'd0);
        vm_init = 1'b0;
        cyc(1);

        // Single request
        set_src(3, 2'd1, 9'o270, 1'b1);
        cyc(1);
        check("single_virq", 32'(vm_virq), 32'b0010);
        stb = 1'b1; una = 1'b0;
        cyc(1);
        check("single_dat", 32'(wbi_dat_o), 32'o000270);
        check("single_ack", 32'(wbi_ack_o), 32'd1);
        check("single_iack", 32'(iack_o), 32'h08);
        stb = 1'b0; ireq[3] = 1'b0;
        cyc(1);
        check("single_ack_drop", 32'(wbi_ack_o), 32'd0);
        check("single_iack_drop", 32'(iack_o), 32'd0);
        cyc(2);

        // Priority
        set_src(1, 2'd0, 9'o060, 1'b1);
        set_src(5, 2'd3, 9'o100, 1'b1);
        set_src(6, 2'd3, 9'o104, 1'b1);
        cyc(1);
        stb = 1'b1;
        cyc(1);
        check("prio_dat1", 32'(wbi_dat_o), 32'o100);
        check("prio_iack1", 32'(iack_o), 32'h20);
        stb = 1'b0; ireq[5] = 1'b0;
        cyc(2);
        stb = 1'b1;
        cyc(1);
        check("prio_dat2", 32'(wbi_dat_o), 32'o104);
        check("prio_iack2", 32'(iack_o), 32'h40);
        stb = 1'b0; ireq = '0;
        cyc(3);

        // No request
        stb = 1'b1;
        acks = 0;
        for (int k = 0; k < 64; k++) begin
            cyc(1);
            if (wbi_ack_o) acks++;
        end
        check("noresp_acks", 32'(acks), 32'd0);
        stb = 1'b0;
        cyc(1);

        // Fast input
        una_dat = 16'o173003; stb = 1'b1; una = 1'b1;
        cyc(1);
        check("una_dat", 32'(wbi_dat_o), 32'o173003);
        check("una_ack", 32'(wbi_ack_o), 32'd1);
        check("una_iack", 32'(iack_o), 32'd0);
        stb = 1'b0; una = 1'b0;
        cyc(1);
        check("una_ack_drop", 32'(wbi_ack_o), 32'd0);
        cyc(2);

        // Hold: strobe held 10 cycles, request change during WAIT
        set_src(2, 2'd2, 9'o344, 1'b1);
        stb = 1'b1;
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            if (wbi_ack_o) acks++;
            if (iack_o[2]) ireq[2] = 1'b0;
            if (k == 3) set_src(7, 2'd3, 9'o500, 1'b1);
        end
        check("hold_acks", 32'(acks), 32'd1);
        check("hold_dat", 32'(wbi_dat_o), 32'o344);
        stb = 1'b0; ireq = '0;
        cyc(3);

        // Reset mid-ACK
        set_src(0, 2'd0, 9'o010, 1'b1);
        stb = 1'b1;
        @(posedge clk);
        #1 vm_init = 1'b1;
        #1;
        check("rst_mid_ack", 32'(wbi_ack_o), 32'd0);
        check("rst_mid_iack", 32'(iack_o), 32'd0);
        check("rst_mid_virq", 32'(vm_virq), 32'd0);
        cyc(1);
        stb = 1'b0;
        cyc(1);
        vm_init = 1'b0;
        cyc(1);
        stb = 1'b1;
        cyc(1);
        check("post_rst_dat", 32'(wbi_dat_o), 32'o010);
        stb = 1'b0; ireq = '0;
        cyc(3);

        // Sub-cycle strobe pulse
        una_dat = 16'h5A5A; una = 1'b1;
        #3 stb = 1'b1;
        @(posedge clk);
        #2 stb = 1'b0;
        cyc(1);
        check("short_ack", 32'(wbi_ack_o), 32'd1);
        check("short_dat", 32'(wbi_dat_o), 32'h5A5A);
        una = 1'b0;
        cyc(3);

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cyc(1);
            for (int i = 0; i < N; i++)
                if (iack_o[i]) ireq[i] = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                int s;
                s = $urandom_range(0, N - 1);
                if (!ireq[s])
                    set_src(s, 2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)), 1'b1);
            end
            if (!stb) begin
                if ($urandom_range(0, 2) == 0) begin
                    stb = 1'b1;
                    una = ($urandom_range(0, 4) == 0);
                    una_dat = 16'($urandom);
                end
            end else if ($urandom_range(0, 1) == 0) begin
                stb = 1'b0;
            end
        end
        stb = 1'b0;
        cyc(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
